// File: rtl/addr_register.sv
// ============================================================================
// addr_register : parametrised address/counter register (load, lane load,
// inc/dec, signed relative add) with zero/wrap/page-cross flags.
// Optional shadow save/restore when ADDR_REG_SHADOW_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module addr_register #(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic [7:0]       byte_in,
  input  logic             load,
  input  logic             load_lo,
  input  logic             load_hi,
  input  logic             inc,
  input  logic             dec,
  input  logic             add,
  input  logic [7:0]       offset,
`ifdef ADDR_REG_SHADOW_EN
  input  logic             save,
  input  logic             restore,
`endif
  output logic [WIDTH-1:0] data_out,
  output logic             zero,
  output logic             wrap,
  output logic             page_cross
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] value;
  logic [WIDTH-1:0] value_nxt;
  logic             wrap_r;
  logic             wrap_nxt;
  logic             page_r;
  logic             page_nxt;

  logic [WIDTH-1:0] off_ext;
  logic [WIDTH+1:0] add_sum;
  logic [WIDTH-1:0] arith_val;
  logic             arith_wrap;
  logic             arith_op;
  logic [WIDTH-1:0] lane_val;
  logic             lane_en;
  logic             upper_changed;
  logic             restore_en;
  logic [WIDTH-1:0] shadow_val;

  assign off_ext = WIDTH'($signed(offset));

  // Two extra bits hold the true signed result so out-of-range adds are visible.
  always_comb begin
    add_sum    = {2'b00, value} + {{2{off_ext[WIDTH-1]}}, off_ext};
    arith_val  = value;
    arith_wrap = 1'b0;
    arith_op   = 1'b0;
    if (add) begin
      arith_val  = add_sum[WIDTH-1:0];
      arith_wrap = |add_sum[WIDTH+1:WIDTH];
      arith_op   = 1'b1;
    end else if (inc && !dec) begin
      arith_val  = value + ONE;
      arith_wrap = &value;
      arith_op   = 1'b1;
    end else if (dec && !inc) begin
      arith_val  = value - ONE;
      arith_wrap = ~|value;
      arith_op   = 1'b1;
    end
  end

  generate
    if (WIDTH > 8) begin : g_hi_lane
      always_comb begin
        lane_val = value;
        if (load_hi) lane_val[WIDTH-1 -: 8] = byte_in;
        if (load_lo) lane_val[7:0] = byte_in;
      end
      assign lane_en       = load_lo | load_hi;
      assign upper_changed = (arith_val[WIDTH-1:8] != value[WIDTH-1:8]);
    end else begin : g_lo_only
      logic unused_load_hi;
      assign unused_load_hi = load_hi;
      always_comb begin
        lane_val      = value;
        lane_val[7:0] = byte_in;
      end
      assign lane_en       = load_lo;
      assign upper_changed = 1'b0;
    end
  endgenerate

`ifdef ADDR_REG_SHADOW_EN
  logic [WIDTH-1:0] shadow;

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow <= RESET_VALUE;
    end else if (save) begin
      shadow <= value;
    end
  end

  assign restore_en = restore;
  assign shadow_val = shadow;
`else
  assign restore_en = 1'b0;
  assign shadow_val = RESET_VALUE;
`endif

  always_comb begin
    value_nxt = value;
    wrap_nxt  = 1'b0;
    page_nxt  = 1'b0;
    if (restore_en) begin
      value_nxt = shadow_val;
    end else if (load) begin
      value_nxt = data_in;
    end else if (lane_en) begin
      value_nxt = lane_val;
    end else if (arith_op) begin
      value_nxt = arith_val;
      wrap_nxt  = arith_wrap;
      page_nxt  = upper_changed;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value  <= RESET_VALUE;
      wrap_r <= 1'b0;
      page_r <= 1'b0;
    end else begin
      value  <= value_nxt;
      wrap_r <= wrap_nxt;
      page_r <= page_nxt;
    end
  end

  assign data_out   = value;
  assign zero       = (value == '0);
  assign wrap       = wrap_r;
  assign page_cross = page_r;

endmodule

`default_nettype wire

// File: tb/tb_addr_register.sv
// Randomised bench: a 16-bit and an 8-bit instance share stimulus and are
// compared each cycle against an integer reference model.
`default_nettype none

module tb_addr_register;

  logic        clk = 1'b0;
  logic        reset, load, load_lo, load_hi, inc, dec, add, save, restore;
  logic [15:0] data_in;
  logic [7:0]  byte_in, offset;

  logic [15:0] out16;
  logic [7:0]  out8;
  logic        zero16, wrap16, pc16, zero8, wrap8, pc8;

  int err_cnt = 0;
  int chk_cnt = 0;

  // Reference state, index 0 = 16-bit instance, 1 = 8-bit instance
  int m_val [2];
  int m_wrap[2];
  int m_pc  [2];
  int m_sh  [2];

  always #5 clk = ~clk;

  addr_register #(.WIDTH(16), .RESET_VALUE(16'h0000)) dut16 (
    .clk(clk), .reset(reset), .data_in(data_in), .byte_in(byte_in),
    .load(load), .load_lo(load_lo), .load_hi(load_hi), .inc(inc), .dec(dec),
    .add(add), .offset(offset),
`ifdef ADDR_REG_SHADOW_EN
    .save(save), .restore(restore),
`endif
    .data_out(out16), .zero(zero16), .wrap(wrap16), .page_cross(pc16)
  );

  addr_register #(.WIDTH(8), .RESET_VALUE(8'h00)) dut8 (
    .clk(clk), .reset(reset), .data_in(data_in[7:0]), .byte_in(byte_in),
    .load(load), .load_lo(load_lo), .load_hi(load_hi), .inc(inc), .dec(dec),
    .add(add), .offset(offset),
`ifdef ADDR_REG_SHADOW_EN
    .save(save), .restore(restore),
`endif
    .data_out(out8), .zero(zero8), .wrap(wrap8), .page_cross(pc8)
  );

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Behaviour as plain integer arithmetic on the register's numeric value.
  function automatic void model_step(int k, int w, bit r, bit ld, bit lo, bit hi,
                                     bit ic, bit dc, bit ad, int d, int b, int off,
                                     bit sv, bit rs);
    int mod   = 1 << w;
    int old   = m_val[k];
    int t;
    bit hi_en = hi && (w > 8);
    m_wrap[k] = 0;
    m_pc[k]   = 0;
    if (r) begin
      m_val[k] = 0;
      m_sh[k]  = 0;
      return;
    end
    if (rs) m_val[k] = m_sh[k];
    else if (ld) m_val[k] = d % mod;
    else if (lo || hi_en) begin
      if (hi_en) m_val[k] = (m_val[k] % (1 << (w - 8))) + b * (1 << (w - 8));
      if (lo)    m_val[k] = (m_val[k] / 256) * 256 + b;
    end else if (ad || (ic != dc)) begin
      if (ad)      t = old + ((off >= 128) ? off - 256 : off);
      else if (ic) t = old + 1;
      else         t = old - 1;
      m_wrap[k] = ((t < 0) || (t >= mod)) ? 1 : 0;
      m_val[k]  = (t + mod) % mod;
      m_pc[k]   = ((w > 8) && (m_val[k] / 256 != old / 256)) ? 1 : 0;
    end
    if (sv) m_sh[k] = old;
  endfunction

  task automatic cycle(bit r, bit ld, bit lo, bit hi, bit ic, bit dc, bit ad,
                       logic [15:0] d, logic [7:0] b, logic [7:0] off, bit sv, bit rs);
    bit sv_e = 1'b0;
    bit rs_e = 1'b0;
`ifdef ADDR_REG_SHADOW_EN
    sv_e = sv;
    rs_e = rs;
`endif
    reset = r; load = ld; load_lo = lo; load_hi = hi; inc = ic; dec = dc; add = ad;
    data_in = d; byte_in = b; offset = off; save = sv; restore = rs;
    @(posedge clk);
    model_step(0, 16, r, ld, lo, hi, ic, dc, ad, int'(d), int'(b), int'(off), sv_e, rs_e);
    model_step(1, 8,  r, ld, lo, hi, ic, dc, ad, int'(d), int'(b), int'(off), sv_e, rs_e);
    #1;
    check_eq("val16",  32'(out16),  32'(m_val[0]));
    check_eq("zero16", 32'(zero16), (m_val[0] == 0) ? 32'd1 : 32'd0);
    check_eq("wrap16", 32'(wrap16), 32'(m_wrap[0]));
    check_eq("pc16",   32'(pc16),   32'(m_pc[0]));
    check_eq("val8",   32'(out8),   32'(m_val[1]));
    check_eq("zero8",  32'(zero8),  (m_val[1] == 0) ? 32'd1 : 32'd0);
    check_eq("wrap8",  32'(wrap8),  32'(m_wrap[1]));
    check_eq("pc8",    32'(pc8),    32'(m_pc[1]));
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 16'h0, 8'h0, 8'h0, 0, 0);
  endtask

  task automatic do_load(logic [15:0] d);
    cycle(0, 1, 0, 0, 0, 0, 0, d, 8'h0, 8'h0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_val[i] = 0; m_wrap[i] = 0; m_pc[i] = 0; m_sh[i] = 0;
    end
    reset = 1'b1; load = 0; load_lo = 0; load_hi = 0; inc = 0; dec = 0; add = 0;
    save = 0; restore = 0; data_in = '0; byte_in = '0; offset = '0;
    @(negedge clk);

    // Reset then idle
    cycle(1, 0, 0, 0, 0, 0, 0, 16'h0, 8'h0, 8'h0, 0, 0);
    idle();
    check_eq("t1_val", 32'(out16), 32'h0000);
    check_eq("t1_zero", 32'(zero16), 32'd1);

    // Increment across a page boundary
    do_load(16'h12FF);
    cycle(0, 0, 0, 0, 1, 0, 0, 16'h0, 8'h0, 8'h0, 0, 0);
    check_eq("t2_val", 32'(out16), 32'h1300);
    check_eq("t2_pc", 32'(pc16), 32'd1);
    idle();
    check_eq("t2_pc_clr", 32'(pc16), 32'd0);

    // Signed relative add, backward and forward with wrap
    do_load(16'h1005);
    cycle(0, 0, 0, 0, 0, 0, 1, 16'h0, 8'h0, 8'hF0, 0, 0);
    check_eq("t3_back", 32'(out16), 32'h0FF5);
    do_load(16'hFFF0);
    cycle(0, 0, 0, 0, 0, 0, 1, 16'h0, 8'h0, 8'h7F, 0, 0);
    check_eq("t3_fwd", 32'(out16), 32'h006F);
    check_eq("t3_wrap", 32'(wrap16), 32'd1);

    // Decrement from zero, dual lane load, inc+dec hold
    do_load(16'h0000);
    cycle(0, 0, 0, 0, 0, 1, 0, 16'h0, 8'h0, 8'h0, 0, 0);
    check_eq("t4_dec", 32'(out16), 32'hFFFF);
    cycle(0, 0, 1, 1, 0, 0, 0, 16'h0, 8'hAB, 8'h0, 0, 0);
    check_eq("t4_lane", 32'(out16), 32'hABAB);
    cycle(0, 0, 0, 0, 1, 1, 0, 16'h0, 8'h0, 8'h0, 0, 0);
    check_eq("t4_hold", 32'(out16), 32'hABAB);

    // 8-bit wrap on increment, then reset dominating a load
    do_load(16'h00FF);
    cycle(0, 0, 0, 0, 1, 0, 0, 16'h0, 8'h0, 8'h0, 0, 0);
    check_eq("t5_val8", 32'(out8), 32'h00);
    check_eq("t5_wrap8", 32'(wrap8), 32'd1);
    cycle(1, 1, 0, 0, 0, 0, 0, 16'h55AA, 8'h0, 8'h0, 0, 0);
    check_eq("t5_rst8", 32'(out8), 32'h00);

`ifdef ADDR_REG_SHADOW_EN
    do_load(16'h1234);
    cycle(0, 0, 0, 0, 1, 0, 0, 16'h0, 8'h0, 8'h0, 1, 0);
    check_eq("t6_inc", 32'(out16), 32'h1235);
    cycle(0, 0, 0, 0, 0, 0, 0, 16'h0, 8'h0, 8'h0, 0, 1);
    check_eq("t6_restore", 32'(out16), 32'h1234);
    cycle(0, 0, 0, 0, 1, 0, 0, 16'h0, 8'h0, 8'h0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 16'h0, 8'h0, 8'h0, 1, 1);
    check_eq("t6_swap_val", 32'(out16), 32'h1234);
    cycle(0, 0, 0, 0, 0, 0, 0, 16'h0, 8'h0, 8'h0, 0, 1);
    check_eq("t6_swap_sh", 32'(out16), 32'h1235);
`endif

    // Randomised operation mix
    for (int n = 0; n < 400; n++) begin
      cycle($urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 5) == 0,  $urandom_range(0, 5) == 0,
            $urandom_range(0, 2) == 0,  $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) == 0,
            16'($urandom), 8'($urandom), 8'($urandom),
            $urandom_range(0, 5) == 0,  $urandom_range(0, 7) == 0);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

`default_nettype wire
